mem_cfg_master: RTL and testbench
=================================

# mem_cfg_master

Initiator for the switch's register-memory interface: takes single read/write commands from a host-side handshake, drives the `mem_sel_en / mem_wr_rd_s / mem_addr / mem_wr_data` request, waits for `mem_ack`, and returns read data or a timeout error. It sits between a test/host controller and the switch's port-address register block, and is the only agent that programs the per-port destination addresses.

## Interface
- `WORD_WIDTH`, 8, width of address and data words.
- `TIMEOUT`, 16, maximum cycles `mem_sel_en` is held without `mem_ack` before aborting; 0 disables the timeout.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  WORD_WIDTH  register address.
- `cmd_wdata`  in  WORD_WIDTH  write data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  WORD_WIDTH  read data (0 for writes and errors).
- `rsp_err`  out  1  qualifies `rsp_valid`: 1 = timed out.
- `err_cnt`  out  8  saturating count of timeouts since reset.
- `mem_sel_en`  out  1  request active.
- `mem_wr_rd_s`  out  1  1 = write, 0 = read.
- `mem_addr`  out  WORD_WIDTH  request address.
- `mem_wr_data`  out  WORD_WIDTH  request write data.
- `mem_rd_data`  in  WORD_WIDTH  responder read data, valid in the ack cycle.
- `mem_ack`  in  1  responder completion, sampled only while `mem_sel_en`=1.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: `cmd_ready`=1, `mem_sel_en`=0. On `cmd_valid`&&`cmd_ready` at an edge: register `cmd_wr/addr/wdata` into the `mem_*` outputs, clear timeout counter, go to REQ.
- REQ: `mem_sel_en`=1; `mem_wr_rd_s/mem_addr/mem_wr_data` held stable for the whole request. Each edge:
  - `mem_ack`=1: capture `mem_rd_data` if read (else capture 0), `rsp_err`<=0, go to RESP.
  - else if TIMEOUT!=0 and counter == TIMEOUT-1: `rsp_rdata`<=0, `rsp_err`<=1, `err_cnt` += 1 (saturate at 255), go to RESP.
  - else counter += 1.
  - Ack and timeout on the same edge: ack wins, no error.
- RESP: `rsp_valid`=1 for exactly one cycle, `mem_sel_en`=0, `cmd_ready`=0; next edge -> IDLE. No response backpressure.
- `mem_ack` in IDLE or RESP is ignored (no state change, no counter effect).
- Commands presented while `cmd_ready`=0 are not accepted; host must hold them.
- Timeout counter width: clog2(TIMEOUT+1), minimum 1 bit.

## Timing
- Reset (synchronous, edge with `rst_n`=0): state IDLE; `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `err_cnt`=0, `mem_sel_en`=0, `mem_wr_rd_s`=0, `mem_addr`=0, `mem_wr_data`=0. Reset mid-request drops `mem_sel_en` at that edge; no response is produced.
- Command accepted at edge T -> `mem_sel_en`=1 during cycle T+1.
- Ack sampled at edge T+1+k (k>=0) -> `rsp_valid`=1 during cycle T+2+k, `mem_sel_en`=0 from same cycle -> `cmd_ready`=1 during cycle T+3+k.
- Minimum command-to-command spacing: 3 cycles; `mem_sel_en` always low for at least 2 cycles between requests.
- Timeout: with no ack, `mem_sel_en` is high for exactly TIMEOUT cycles, then `rsp_valid`&&`rsp_err` for one cycle.
- All outputs are registered; no combinational path from `mem_ack`/`mem_rd_data` to any output.

## Test plan
- Write: cmd wr=1 addr=0x02 wdata=0xA5, responder acks 2 cycles after `mem_sel_en` rises -> `mem_sel_en` high 3 cycles with addr=0x02, data=0xA5, `mem_wr_rd_s`=1; `rsp_valid` pulse with `rsp_err`=0, `rsp_rdata`=0.
- Read: cmd wr=0 addr=0x01, responder acks in first `mem_sel_en` cycle with `mem_rd_data`=0x3C -> `rsp_rdata`=0x3C, `rsp_err`=0, `cmd_ready` back high 3 cycles after acceptance.
- Timeout: TIMEOUT=16, responder never acks -> `mem_sel_en` high exactly 16 cycles, `rsp_err`=1, `rsp_rdata`=0, `err_cnt`=1; 300 such timeouts -> `err_cnt`=255.
- Ack on final timeout cycle (cycle 16) with data 0x77 -> `rsp_err`=0, `rsp_rdata`=0x77, `err_cnt` unchanged.
- Back-to-back: `cmd_valid` held continuously with 4 writes to addr 0..3 -> each accepted only when `cmd_ready`=1, 4 distinct requests in order, `mem_sel_en` low >=2 cycles between them; stray `mem_ack` in IDLE has no effect.
- Reset asserted mid-REQ -> `mem_sel_en`=0 after that edge, no `rsp_valid`, `err_cnt`=0, `cmd_ready`=1 after reset release.

Source files
------------

// File: rtl/mem_cfg_master.sv
// Single-outstanding initiator for the switch register-memory interface.
// Accepts one host command at a time, runs one mem_* request, returns data or a timeout error.
module mem_cfg_master #(
  parameter int WORD_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [WORD_WIDTH-1:0] cmd_addr,
  input  logic [WORD_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [7:0]            err_cnt,
  output logic                  mem_sel_en,
  output logic                  mem_wr_rd_s,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wr_data,
  input  logic [WORD_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_ack
);

  localparam int CW             = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM_I         = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] TLIM = CW'(TLIM_I);
  localparam logic TO_EN        = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_cmd_ready, w_cmd_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [WORD_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic [7:0]            r_err_cnt, w_err_cnt_nxt;
  logic                  r_sel_en, w_sel_en_nxt;
  logic                  r_wr, w_wr_nxt;
  logic [WORD_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [WORD_WIDTH-1:0] r_wdata, w_wdata_nxt;

  // Next-state and next-output decode; every output is the registered copy of these.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_err_cnt_nxt   = r_err_cnt;
    w_sel_en_nxt    = r_sel_en;
    w_wr_nxt        = r_wr;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_state_nxt     = REQ;
          w_cnt_nxt       = '0;
          w_cmd_ready_nxt = 1'b0;
          w_sel_en_nxt    = 1'b1;
          w_wr_nxt        = cmd_wr;
          w_addr_nxt      = cmd_addr;
          w_wdata_nxt     = cmd_wdata;
        end else begin
          w_cmd_ready_nxt = 1'b1;
          w_sel_en_nxt    = 1'b0;
        end
      end
      REQ: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (mem_ack) begin
          w_state_nxt     = RESP;
          w_sel_en_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = r_wr ? {WORD_WIDTH{1'b0}} : mem_rd_data;
        end else if (TO_EN && (r_cnt == TLIM)) begin
          w_state_nxt     = RESP;
          w_sel_en_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = {WORD_WIDTH{1'b0}};
          if (r_err_cnt != 8'hFF) begin
            w_err_cnt_nxt = r_err_cnt + 8'd1;
          end else begin
            w_err_cnt_nxt = r_err_cnt;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      RESP: begin
        w_state_nxt     = IDLE;
        w_cmd_ready_nxt = 1'b1;
        w_sel_en_nxt    = 1'b0;
      end
      default: begin
        w_state_nxt     = IDLE;
        w_cmd_ready_nxt = 1'b1;
        w_sel_en_nxt    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {WORD_WIDTH{1'b0}};
      r_rsp_err   <= 1'b0;
      r_err_cnt   <= 8'd0;
      r_sel_en    <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= {WORD_WIDTH{1'b0}};
      r_wdata     <= {WORD_WIDTH{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_sel_en    <= w_sel_en_nxt;
      r_wr        <= w_wr_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign err_cnt     = r_err_cnt;
  assign mem_sel_en  = r_sel_en;
  assign mem_wr_rd_s = r_wr;
  assign mem_addr    = r_addr;
  assign mem_wr_data = r_wdata;

endmodule

// File: tb/tb_mem_cfg_master.sv
// Directed self-checking bench for mem_cfg_master (TIMEOUT=16, 8-bit words).
module tb_mem_cfg_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata, err_cnt;
  logic       mem_sel_en, mem_wr_rd_s;
  logic [7:0] mem_addr, mem_wr_data, mem_rd_data;
  logic       mem_ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_cfg_master #(.WORD_WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_cnt(err_cnt),
    .mem_sel_en(mem_sel_en), .mem_wr_rd_s(mem_wr_rd_s), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack)
  );

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         k;          // ack in sel cycle k (0-based); -1 = never
    logic [7:0] rd;
    int         exp_sel;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic [7:0] exp_errcnt;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One command end to end; returns what was observed.
  task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input int k, input logic [7:0] rd,
                        output int sel_cycles, output logic stable_ok,
                        output logic r_valid, output logic [7:0] r_rdata, output logic r_err,
                        output logic r_ready, output logic a_ready, output logic a_valid,
                        output logic timed_out);
    int w;
    timed_out = 1'b0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    w = 0;
    while (!cmd_ready && w < 10) begin tick(); w++; end
    if (!cmd_ready) timed_out = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00; cmd_wr = 1'b0;
    sel_cycles = 0;
    stable_ok  = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (!mem_sel_en) break;
      sel_cycles++;
      if (mem_addr !== a || mem_wr_data !== d || mem_wr_rd_s !== wr) stable_ok = 1'b0;
      mem_ack     = (c == k);
      mem_rd_data = (c == k) ? rd : 8'hEE;
      tick();
      if (c == 39) timed_out = 1'b1;
    end
    mem_ack = 1'b0; mem_rd_data = 8'h00;
    r_valid = rsp_valid; r_rdata = rsp_rdata; r_err = rsp_err; r_ready = cmd_ready;
    tick();
    a_ready = cmd_ready; a_valid = rsp_valid;
  endtask

  initial begin
    int         sel;
    logic       stab, rv, re, rr, ar, av, to;
    logic [7:0] rdat;
    int         idx, nreq, nrsp, gap, min_gap, cyc;
    logic       prev_sel, order_ok, acc;

    vecs[0] = '{1'b1, 8'h02, 8'hA5,  2, 8'h5A,  3, 8'h00, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 8'h01, 8'h00,  0, 8'h3C,  1, 8'h3C, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 8'h07, 8'h00, -1, 8'h00, 16, 8'h00, 1'b1, 8'd1};
    vecs[3] = '{1'b0, 8'h03, 8'h00, 15, 8'h77, 16, 8'h77, 1'b0, 8'd1};
    vecs[4] = '{1'b1, 8'hFF, 8'hC3, -1, 8'h00, 16, 8'h00, 1'b1, 8'd2};
    vecs[5] = '{1'b0, 8'h80, 8'h00,  5, 8'h81,  6, 8'h81, 1'b0, 8'd2};
    vecs[6] = '{1'b1, 8'h10, 8'hFF,  0, 8'h99,  1, 8'h00, 1'b0, 8'd2};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    mem_ack = 1'b0; mem_rd_data = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    chk("rst_err_cnt",   {24'd0, err_cnt}, 32'd0);
    chk("rst_sel_en",    {31'd0, mem_sel_en}, 32'd0);
    chk("rst_mem_bus",   {15'd0, mem_wr_rd_s, mem_addr, mem_wr_data}, 32'd0);
    tick();

    for (int i = 0; i < 7; i++) begin
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].k, vecs[i].rd,
             sel, stab, rv, rdat, re, rr, ar, av, to);
      chk($sformatf("v%0d_bound", i), {31'd0, to}, 32'd0);
      chk($sformatf("v%0d_sel_cycles", i), sel, vecs[i].exp_sel);
      chk($sformatf("v%0d_req_stable", i), {31'd0, stab}, 32'd1);
      chk($sformatf("v%0d_rsp_valid", i), {31'd0, rv}, 32'd1);
      chk($sformatf("v%0d_rsp_rdata", i), {24'd0, rdat}, {24'd0, vecs[i].exp_rdata});
      chk($sformatf("v%0d_rsp_err", i), {31'd0, re}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_ready_in_resp", i), {31'd0, rr}, 32'd0);
      chk($sformatf("v%0d_ready_after", i), {31'd0, ar}, 32'd1);
      chk($sformatf("v%0d_valid_after", i), {31'd0, av}, 32'd0);
      chk($sformatf("v%0d_err_cnt", i), {24'd0, err_cnt}, {24'd0, vecs[i].exp_errcnt});
    end

    // Saturation: timeouts up to 254 total, then well past 255.
    for (int i = 2; i < 254; i++)
      do_cmd(1'b0, 8'h44, 8'h00, -1, 8'h00, sel, stab, rv, rdat, re, rr, ar, av, to);
    chk("err_cnt_254", {24'd0, err_cnt}, 32'd254);
    for (int i = 254; i < 302; i++)
      do_cmd(1'b0, 8'h44, 8'h00, -1, 8'h00, sel, stab, rv, rdat, re, rr, ar, av, to);
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
    chk("sat_last_err", {31'd0, re}, 32'd1);

    // Stray ack in IDLE with no command.
    mem_ack = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid || mem_sel_en || !cmd_ready) nrsp++;
    end
    chk("stray_ack_idle", nrsp, 0);

    // Back-to-back writes with cmd_valid held and ack held high throughout.
    idx = 0; nreq = 0; nrsp = 0; gap = 0; min_gap = 99; prev_sel = 1'b0; order_ok = 1'b1;
    for (cyc = 0; cyc < 60; cyc++) begin
      cmd_valid = (idx < 4); cmd_wr = 1'b1;
      cmd_addr  = 8'(idx); cmd_wdata = 8'h50 + 8'(idx);
      acc = cmd_ready && cmd_valid;
      tick();
      if (acc) idx++;
      if (mem_sel_en && !prev_sel) begin
        if (mem_addr !== 8'(nreq) || mem_wr_data !== 8'h50 + 8'(nreq) || !mem_wr_rd_s)
          order_ok = 1'b0;
        if (nreq > 0 && gap < min_gap) min_gap = gap;
        nreq++;
      end
      gap = mem_sel_en ? 0 : gap + 1;
      if (rsp_valid) nrsp++;
      prev_sel = mem_sel_en;
    end
    cmd_valid = 1'b0; mem_ack = 1'b0;
    chk("b2b_accepted", idx, 4);
    chk("b2b_requests", nreq, 4);
    chk("b2b_responses", nrsp, 4);
    chk("b2b_order", {31'd0, order_ok}, 32'd1);
    chk("b2b_min_gap_ge2", {31'd0, (min_gap >= 2)}, 32'd1);
    chk("b2b_err_cnt", {24'd0, err_cnt}, 32'd255);

    // Reset in the middle of a request.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h09;
    tick();
    cmd_valid = 1'b0;
    chk("mid_sel_before", {31'd0, mem_sel_en}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_sel", {31'd0, mem_sel_en}, 32'd0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid || mem_sel_en) nrsp++;
    end
    chk("mid_rst_no_rsp", nrsp, 0);
    chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
